module_codificador_hamming_tx: RTL and testbench
================================================

# module_codificador_hamming_tx

Hamming(7,4) transmitter: accepts a 4-bit data word over a valid/ready handshake and computes the three check bits. It optionally flips one code bit for error-injection tests, registers the 7-bit code word, and shifts it out as a serial frame. It is the sending end of the link whose receiving end computes the syndrome and corrects the received word, and it uses the same bit order [i3,i2,i1,c2,i0,c1,c0].

## Interface
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 1..255.
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  4  data word [i3,i2,i1,i0]; sampled on acceptance.
- valid_in  input  1  data_in valid.
- ready_out  output  1  block can accept a word; handshake completes when valid_in && ready_out at a rising edge.
- error_en  input  1  enable error injection; sampled on acceptance.
- error_pos  input  3  code bit index to flip (0..6); 7 = no flip; sampled on acceptance.
- code_out  output  7  registered code word [i3,i2,i1,c2,i0,c1,c0], including any injected error; held until next acceptance.
- tx_serial  output  1  serial line; idle high.
- tx_busy  output  1  high while a frame is on the line.
- done  output  1  one-cycle pulse at end of frame.

## Operation
- Check bits:
  - c0 = i0^i1^i3 (code index 0)
  - c1 = i0^i2^i3 (index 1)
  - c2 = i1^i2^i3 (index 3)
  - Data bits: i0 at index 2, i1 at 4, i2 at 5, i3 at 6.
- Injection: if error_en=1 and error_pos≤6, code_out[error_pos] is inverted. error_pos=7 or error_en=0 leaves the word clean.
- FSM states:
  - IDLE: ready_out=1, tx_serial=1. On handshake, load code_out and go to START.
  - START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 7 bits, LSB first (code_out[0] first), each for CLKS_PER_BIT cycles. A 3-bit bit index tracks the position; after index 6 completes, go to STOP.
  - STOP: tx_serial=1 for CLKS_PER_BIT cycles, then go to IDLE with done=1 for that single cycle.
- Bit-period counter: width $clog2(CLKS_PER_BIT+1). Counts 0..CLKS_PER_BIT-1, clears on every state/bit transition.
- The shift register is separate from code_out; code_out stays stable for the whole frame.
- valid_in while ready_out=0 is ignored. data_in, error_en and error_pos changes mid-frame have no effect.
- tx_busy = 1 in START, DATA and STOP.

## Timing
- Reset values: ready_out=1, tx_serial=1, tx_busy=0, done=0, code_out=0, FSM=IDLE, counters=0.
- Reset asserted mid-frame aborts the frame immediately (asynchronous): line returns high, no done pulse.
- Handshake at edge N:
  - After edge N: code_out valid, ready_out=0, tx_busy=1, tx_serial=0.
  - Start bit occupies cycles N+1..N+C (C = CLKS_PER_BIT).
  - Data bit k occupies cycles N+1+(k+1)C .. N+(k+2)C.
  - Stop bit occupies cycles N+1+8C .. N+9C.
- After edge N+9C: ready_out=1, tx_busy=0, done=1 for exactly one cycle.
- ready_out is low for exactly 9C cycles per frame.
- Back-to-back with valid_in held high: the next acceptance is at edge N+9C+1, so the frame period is 9C+1 cycles. The line stays high for one cycle between frames.
- C=1 is legal: each bit lasts one cycle.

## Test plan
- Reset: assert rst_n=0 → ready_out=1, tx_serial=1, tx_busy=0, done=0, code_out=7'b0000000.
- Encoding sweep, all 16 data_in values, error_en=0. Expected code_out: 4'b0000→7'b0000000; 4'b1011→7'b1010101; 4'b0001→7'b0000111; 4'b1111→7'b1111111.
- Serial frame, data_in=4'b1011, C=4 → line low 4 cycles, then 1,0,1,0,1,0,1 at 4 cycles each, then high 4 cycles, then done pulse. ready_out low exactly 36 cycles.
- Injection:
  - data_in=4'b1011, error_en=1, error_pos=2 → code_out=7'b1010001, serialized accordingly.
  - error_pos=7 → code_out=7'b1010101.
- Back-to-back words 4'b0001 then 4'b1111 with valid_in held high, C=1 → second acceptance exactly 10 cycles after the first. Mid-frame changes to data_in don't alter the first frame.
- Reset mid-DATA: pull rst_n low during bit 3 → tx_serial=1 immediately, no done pulse. After release, ready_out=1 and a new frame sends correctly.

Source files
------------

// File: rtl/module_codificador_hamming_tx_if.sv
// Handshake and line-side signals of the Hamming(7,4) transmitter.
//   master : drives data_in, valid_in, error_en, error_pos; observes everything else
//   slave  : the transmitter side (inverse directions)
interface module_codificador_hamming_tx_if;
  logic [3:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       error_en;
  logic [2:0] error_pos;
  logic [6:0] code_out;
  logic       tx_serial;
  logic       tx_busy;
  logic       done;

  modport master (
    output data_in, valid_in, error_en, error_pos,
    input  ready_out, code_out, tx_serial, tx_busy, done
  );

  modport slave (
    input  data_in, valid_in, error_en, error_pos,
    output ready_out, code_out, tx_serial, tx_busy, done
  );
endinterface

// File: rtl/module_codificador_hamming_tx.sv
// Hamming(7,4) transmitter. Encodes a 4-bit word into [i3,i2,i1,c2,i0,c1,c0],
// optionally flips one code bit, registers it and sends it as a serial frame.
// Frame: start bit (low), 7 code bits LSB first, stop bit (high); each bit lasts
// CLKS_PER_BIT cycles.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave modport: data_in/valid_in/ready_out handshake, error_en,
//           error_pos, code_out, tx_serial, tx_busy, done
//
// state | meaning
// IDLE  | line high, ready for a word
// START | start bit (line low)
// DATA  | shifting out code bits, bit_idx = current bit
// STOP  | stop bit (line high); done pulses when leaving it
module module_codificador_hamming_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  module_codificador_hamming_tx_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [6:0]    shreg;
  logic [6:0]    code_q;
  logic          done_q;

  logic          accept;
  logic          bit_end;
  logic          frame_end;
  logic [6:0]    code_clean;
  logic [6:0]    flip_mask;
  logic [6:0]    code_nx;

  assign accept  = bus.valid_in && (state == IDLE);
  assign bit_end = (cnt == CNT_LAST);

  // Encoder plus error injection; error_pos 7 means no flip.
  always_comb begin
    code_clean = {bus.data_in[3], bus.data_in[2], bus.data_in[1],
                  bus.data_in[1] ^ bus.data_in[2] ^ bus.data_in[3],
                  bus.data_in[0],
                  bus.data_in[0] ^ bus.data_in[2] ^ bus.data_in[3],
                  bus.data_in[0] ^ bus.data_in[1] ^ bus.data_in[3]};
    flip_mask = 7'd0;
    if (bus.error_en && (bus.error_pos != 3'd7))
      flip_mask = 7'd1 << bus.error_pos;
    code_nx = code_clean ^ flip_mask;
  end

  always_comb begin
    state_nx  = state;
    frame_end = 1'b0;
    case (state)
      IDLE:    if (accept) state_nx = START;
      START:   if (bit_end) state_nx = DATA;
      DATA:    if (bit_end && (bit_idx == 3'd6)) state_nx = STOP;
      STOP:    if (bit_end) begin
                 state_nx  = IDLE;
                 frame_end = 1'b1;
               end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 7'd0;
      code_q  <= 7'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= frame_end;

      // Idle holds the counter at zero so the start bit begins from a clean count.
      if ((state == IDLE) || bit_end) cnt <= '0;
      else                            cnt <= cnt + 1'b1;

      if (state != DATA)
        bit_idx <= 3'd0;
      else if (bit_end)
        bit_idx <= (bit_idx == 3'd6) ? 3'd0 : bit_idx + 3'd1;

      // Shift copy is separate so code_out stays stable for the whole frame.
      if (accept) begin
        shreg  <= code_nx;
        code_q <= code_nx;
      end else if ((state == DATA) && bit_end) begin
        shreg <= shreg >> 1;
      end
    end
  end

  always_comb begin
    bus.tx_serial = 1'b1;
    case (state)
      START:   bus.tx_serial = 1'b0;
      DATA:    bus.tx_serial = shreg[0];
      default: bus.tx_serial = 1'b1;
    endcase
  end

  assign bus.ready_out = (state == IDLE);
  assign bus.tx_busy   = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.code_out  = code_q;

endmodule

// File: tb/tb_module_codificador_hamming_tx.sv
module tb_module_codificador_hamming_tx;

  logic clk;
  logic rst_n;

  module_codificador_hamming_tx_if bus_a ();
  module_codificador_hamming_tx_if bus_b ();

  module_codificador_hamming_tx #(.CLKS_PER_BIT(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  module_codificador_hamming_tx #(.CLKS_PER_BIT(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [6:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference encoder written as classic Hamming positions 1..7:
  // parity at position p covers every position j with (j & p) != 0.
  function automatic logic [6:0] hamming_ref(input logic [3:0] d);
    logic [6:0] w;
    logic par;
    w = 7'd0;
    w[2] = d[0]; w[4] = d[1]; w[5] = d[2]; w[6] = d[3];
    for (int p = 1; p <= 4; p = p * 2) begin
      par = 1'b0;
      for (int j = 1; j <= 7; j++)
        if (((j & p) != 0) && (j != p)) par = par ^ w[j-1];
      w[p-1] = par;
    end
    return w;
  endfunction

  // One full frame on the C=4 instance, with inputs scrambled right after acceptance.
  task automatic run_frame_a(input string tag, input logic [3:0] d, input logic en,
                             input logic [2:0] pos, input logic [6:0] exp_code);
    logic [6:0] exp;
    int bad;
    int low;
    logic e;
    @(negedge clk);
    bus_a.data_in   = d;
    bus_a.error_en  = en;
    bus_a.error_pos = pos;
    bus_a.valid_in  = 1'b1;
    sb.push_back(exp_code);
    chk({tag, "_ready_idle"}, bus_a.ready_out, 1);
    @(posedge clk);
    @(negedge clk);
    bus_a.valid_in  = 1'b0;
    bus_a.data_in   = ~d;
    bus_a.error_en  = ~en;
    bus_a.error_pos = pos + 3'd1;
    exp = sb.pop_front();
    chk({tag, "_code"}, bus_a.code_out, exp);
    bad = 0;
    low = 0;
    for (int i = 0; i < 36; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 4)       e = 1'b0;
      else if (i < 32) e = exp[(i/4)-1];
      else             e = 1'b1;
      if (bus_a.tx_serial !== e) bad++;
      if (bus_a.tx_busy !== 1'b1) bad++;
      if (bus_a.ready_out === 1'b0) low++;
    end
    chk({tag, "_line_errs"}, bad, 0);
    chk({tag, "_ready_low"}, low, 36);
    @(negedge clk);
    chk({tag, "_done"}, bus_a.done, 1);
    chk({tag, "_ready_end"}, bus_a.ready_out, 1);
    chk({tag, "_busy_end"}, bus_a.tx_busy, 0);
    chk({tag, "_code_hold"}, bus_a.code_out, exp);
    @(negedge clk);
    chk({tag, "_done_clr"}, bus_a.done, 0);
  endtask

  // Nine line samples of a C=1 frame starting at the current negedge.
  task automatic capture_b(input string tag, input logic [6:0] exp);
    int bad;
    logic e;
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0)      e = 1'b0;
      else if (i == 8) e = 1'b1;
      else             e = exp[i-1];
      if (bus_b.tx_serial !== e) bad++;
    end
    chk({tag, "_line_errs"}, bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] exp;
    logic [3:0] d;
    logic found;
    time t1, t2;
    int ndone;

    rst_n = 1'b0;
    bus_a.data_in = 4'd0; bus_a.valid_in = 1'b0; bus_a.error_en = 1'b0; bus_a.error_pos = 3'd7;
    bus_b.data_in = 4'd0; bus_b.valid_in = 1'b0; bus_b.error_en = 1'b0; bus_b.error_pos = 3'd7;
    #1;
    chk("rst_ready", bus_a.ready_out, 1);
    chk("rst_line", bus_a.tx_serial, 1);
    chk("rst_busy", bus_a.tx_busy, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_code", bus_a.code_out, 7'b0000000);
    chk("rst_b_ready", bus_b.ready_out, 1);
    chk("rst_b_line", bus_b.tx_serial, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Encoding sweep; the four listed words use literal expectations.
    for (int k = 0; k < 16; k++) begin
      d = 4'(k);
      case (d)
        4'b0000: exp = 7'b0000000;
        4'b1011: exp = 7'b1010101;
        4'b0001: exp = 7'b0000111;
        4'b1111: exp = 7'b1111111;
        default: exp = hamming_ref(d);
      endcase
      run_frame_a($sformatf("enc%0d", k), d, 1'b0, 3'($urandom_range(0, 6)), exp);
    end

    run_frame_a("inj_pos2", 4'b1011, 1'b1, 3'd2, 7'b1010001);
    run_frame_a("inj_pos7", 4'b1011, 1'b1, 3'd7, 7'b1010101);
    run_frame_a("inj_pos6", 4'b0110, 1'b1, 3'd6, hamming_ref(4'b0110) ^ 7'b1000000);

    // Back-to-back on the C=1 instance.
    @(negedge clk);
    bus_b.data_in  = 4'b0001;
    bus_b.valid_in = 1'b1;
    sb.push_back(7'b0000111);
    sb.push_back(7'b1111111);
    chk("b2b_ready0", bus_b.ready_out, 1);
    @(posedge clk);
    t1 = $time;
    @(negedge clk);
    bus_b.data_in = 4'b1111;
    exp = sb.pop_front();
    chk("b2b_code1", bus_b.code_out, exp);
    capture_b("b2b_f1", exp);
    found = 1'b0;
    t2 = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus_b.ready_out === 1'b1 && bus_b.valid_in) begin
        chk("b2b_gap_line", bus_b.tx_serial, 1);
        chk("b2b_done", bus_b.done, 1);
        @(posedge clk);
        t2 = $time;
        found = 1'b1;
      end
    end
    chk("b2b_found", found, 1);
    chk("b2b_period", 32'((t2 - t1) / 10), 10);
    @(negedge clk);
    bus_b.data_in  = 4'b0000;
    bus_b.valid_in = 1'b0;
    exp = sb.pop_front();
    chk("b2b_code2", bus_b.code_out, exp);
    capture_b("b2b_f2", exp);

    // Reset during data bit 3 of a C=4 frame.
    @(negedge clk);
    bus_a.data_in  = 4'b0001;
    bus_a.error_en = 1'b0;
    bus_a.valid_in = 1'b1;
    sb.push_back(7'b0000111);
    @(posedge clk);
    @(negedge clk);
    bus_a.valid_in = 1'b0;
    repeat (17) @(negedge clk);
    chk("rstmid_bit3", bus_a.tx_serial, hamming_ref(4'b0001) >> 3 & 1);
    chk("rstmid_busy_before", bus_a.tx_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_line", bus_a.tx_serial, 1);
    chk("rstmid_busy", bus_a.tx_busy, 0);
    chk("rstmid_ready", bus_a.ready_out, 1);
    sb.delete();
    ndone = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus_a.done !== 1'b0) ndone++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus_a.done !== 1'b0) ndone++;
    end
    chk("rstmid_no_done", ndone, 0);
    chk("rstmid_ready_after", bus_a.ready_out, 1);
    chk("rstmid_code_cleared", bus_a.code_out, 0);
    run_frame_a("post_rst", 4'b1101, 1'b0, 3'd7, hamming_ref(4'b1101));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
